// File: rtl/output_uart_tx_pkg.sv
// rtl/output_uart_tx_pkg.sv - shared types and constants for the output-port UART transmitter
package output_uart_tx_pkg;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/output_uart_tx_fifo.sv
// rtl/output_uart_tx_fifo.sv - synchronous FIFO; full/empty decoded from wrap-extended pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Pointers carry one extra wrap bit so equal indices can mean either full or empty.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/output_uart_tx.sv
// rtl/output_uart_tx.sv - queues OUT-register writes and sends them as 8N1 UART frames, LSB first
module output_uart_tx
  import output_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_wr_en,
  input  logic [UART_DATA_BITS-1:0] i_wr_data,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_fifo_full,
  output logic                      o_overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]          BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST  = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            r_state, w_state_next;
  logic [CNT_W-1:0]          r_baud_cnt, w_baud_cnt_next;
  logic [UART_BIT_IDX_W-1:0] r_bit_idx, w_bit_idx_next;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
  logic [UART_DATA_BITS-1:0] w_fifo_dout;
  logic r_tx, w_tx_next;
  logic r_busy, w_busy_next;
  logic r_overflow;
  logic w_fifo_full, w_fifo_empty, w_pop, w_push_ok, w_tick;

  assign w_push_ok = i_wr_en & ~w_fifo_full;
  assign w_tick    = (r_baud_cnt == BAUD_LAST);

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_wr_en),
    .i_pop   (w_pop),
    .i_din   (i_wr_data),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_pop           = 1'b0;
    w_tx_next       = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop           = 1'b1;
          w_shift_next    = w_fifo_dout;
          w_baud_cnt_next = '0;
          w_state_next    = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_baud_cnt_next = '0;
          w_bit_idx_next  = '0;
          w_state_next    = S_DATA;
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_baud_cnt_next = '0;
          w_shift_next    = r_shift >> 1;
          if (r_bit_idx == BIT_LAST) w_state_next = S_STOP;
          else                       w_bit_idx_next = r_bit_idx + UART_BIT_IDX_W'(1);
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_baud_cnt_next = '0;
          // Chain straight into the next frame so queued bytes leave without an idle bit.
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_fifo_dout;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase

    // A pop always leads to START, so only a push can keep an otherwise empty FIFO busy.
    w_busy_next = (w_state_next != S_IDLE) | ~w_fifo_empty | w_push_ok;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      if (i_wr_en && w_fifo_full) r_overflow <= 1'b1;
    end
  end

  assign o_tx        = r_tx;
  assign o_busy      = r_busy;
  assign o_fifo_full = w_fifo_full;
  assign o_overflow  = r_overflow;

endmodule
